// File: rtl/problema_lcd_pkg.sv
// Shared constants for the push-button PIO: register map and default debounce length.
package problema_lcd_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA    = 2'd0,
    ADDR_DIR     = 2'd1,
    ADDR_IRQMASK = 2'd2,
    ADDR_EDGECAP = 2'd3
  } reg_addr_e;

  // 10 ms of stable level at 50 MHz.
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;

endpackage

// File: rtl/problema_lcd_botao_pio_if.sv
// Avalon-MM slave bus bundle for the push-button PIO (active-low strobes, registered readdata).
interface problema_lcd_botao_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, read_n, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read_n, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/problema_lcd_debounce.sv
// One button bit: 2-FF synchronizer plus stable-level debouncer with a press (1->0) strobe.
// The counter is built only when PROBLEMA_LCD_DEBOUNCE_EN is defined; otherwise stable follows s2.
module problema_lcd_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic stable,
  output logic press
);

  logic s1_q, s2_q;
  logic stable_q, stable_d;

`ifdef PROBLEMA_LCD_DEBOUNCE_EN
  localparam int unsigned       CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every variable gets a default at the top of always_comb, so no path can infer a latch.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (s2_q != stable_q) begin
      // The clock that would bring the count to DEBOUNCE_CYCLES accepts the level,
      // so the counter never passes CNT_LAST and cannot wrap.
      if (cnt_q >= CNT_LAST) begin
        stable_d = s2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  always_comb begin
    stable_d = s2_q;
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q     <= 1'b1;
      s2_q     <= 1'b1;
      stable_q <= 1'b1;
    end else begin
      s1_q     <= din;
      s2_q     <= s1_q;
      stable_q <= stable_d;
    end
  end

  assign stable = stable_q;
  // Press is flagged on the clock that stable falls, so capture lands on the same edge.
  assign press  = stable_q & ~stable_d;

endmodule

// File: rtl/problema_lcd_botao_pio.sv
// Avalon-MM push-button input port: debounced data, per-bit irq mask, W1C press capture, level irq.
// Define PROBLEMA_LCD_DEBOUNCE_EN to build the debounce counters; otherwise bits pass after the synchronizer.
module problema_lcd_botao_pio
  import problema_lcd_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset_n,
  problema_lcd_botao_pio_if.slave bus,
  input  logic [WIDTH-1:0]        in_port,
  output logic                    irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] press;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    problema_lcd_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (in_port[i]),
      .stable  (stable[i]),
      .press   (press[i])
    );
  end

  logic             wr_en, rd_en;
  reg_addr_e        addr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] clear_mask;

  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [31:0]      readdata_q, readdata_d;

  assign wr_en = bus.chipselect & ~bus.write_n;
  assign rd_en = bus.chipselect & ~bus.read_n;
  assign addr  = reg_addr_e'(bus.address);
  assign wdata = bus.writedata[WIDTH-1:0];

  // Upper writedata bits are don't-care when WIDTH < 32.
  logic unused_wdata;
  assign unused_wdata = ^bus.writedata;

  always_comb begin
    irqmask_d  = irqmask_q;
    readdata_d = readdata_q;
    clear_mask = '0;

    if (wr_en && addr == ADDR_IRQMASK) irqmask_d  = wdata;
    if (wr_en && addr == ADDR_EDGECAP) clear_mask = wdata;

    // A press arriving on the clearing clock wins over the clear.
    edgecap_d = (edgecap_q & ~clear_mask) | press;

    if (rd_en) begin
      unique case (addr)
        ADDR_DATA:    readdata_d = 32'(stable);
        ADDR_DIR:     readdata_d = '0;
        ADDR_IRQMASK: readdata_d = 32'(irqmask_q);
        ADDR_EDGECAP: readdata_d = 32'(edgecap_q);
        default:      readdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
    end else begin
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign irq          = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_problema_lcd_botao_pio.sv
// Scoreboard bench for problema_lcd_botao_pio (WIDTH=4, DEBOUNCE_CYCLES=4); expectations follow
// PROBLEMA_LCD_DEBOUNCE_EN so the same bench covers both builds.
module tb_problema_lcd_botao_pio;
  import problema_lcd_pkg::*;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DC    = 4;
`ifdef PROBLEMA_LCD_DEBOUNCE_EN
  localparam int          LAT         = 2 + DC;
  localparam logic [31:0] SHORT_GLITCH = 32'h0;
`else
  localparam int          LAT         = 3;
  localparam logic [31:0] SHORT_GLITCH = 32'h2;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic [WIDTH-1:0] in_port;
  logic             irq;

  problema_lcd_botao_pio_if bus ();

  problema_lcd_botao_pio #(
    .WIDTH           (WIDTH),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .in_port (in_port),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic rd_seen  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: a read access at a posedge presents readdata for the following negedge.
  always @(posedge clk) rd_seen <= bus.chipselect & ~bus.read_n;

  always @(negedge clk) begin
    if (rd_seen) begin
      if (sb.size() == 0) begin
        check("unexpected read", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check(e.name, bus.readdata, e.exp);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_read(input reg_addr_e a, input logic [31:0] exp, input string name);
    sb.push_back('{name: name, exp: exp});
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.read_n     = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.read_n     = 1'b1;
  endtask

  task automatic bus_write(input reg_addr_e a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n        = 1'b0;
    in_port        = 4'hF;
    bus.address    = ADDR_DATA;
    bus.chipselect = 1'b0;
    bus.read_n     = 1'b1;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    tick(3);
    check("reset readdata", bus.readdata, 32'h0);
    check("reset irq", {31'b0, irq}, 32'h0);
    reset_n = 1'b1;
    tick(2);

    // Register map after reset.
    bus_read(ADDR_DATA,    32'hF, "data after reset");
    bus_read(ADDR_DIR,     32'h0, "direction reads 0");
    bus_read(ADDR_IRQMASK, 32'h0, "irqmask reset");
    bus_read(ADDR_EDGECAP, 32'h0, "edgecap reset");
    bus_write(ADDR_DATA, 32'h0);
    bus_write(ADDR_DIR,  32'hF);
    bus_read(ADDR_DATA, 32'hF, "data ignores writes");
    bus_read(ADDR_DIR,  32'h0, "direction ignores writes");

    // Press bit 0 with irqmask=0: data and capture change exactly on edge LAT.
    in_port = 4'hE;
    tick(LAT - 1);
    bus_read(ADDR_DATA, 32'hF, "data before press latency");
    bus_read(ADDR_DATA, 32'hE, "data after press latency");
    bus_read(ADDR_EDGECAP, 32'h1, "bit0 press captured");
    check("irq masked", {31'b0, irq}, 32'h0);
    in_port = 4'hF;
    tick(LAT + 2);
    bus_read(ADDR_EDGECAP, 32'h1, "release not captured");
    bus_write(ADDR_EDGECAP, 32'h1);
    bus_read(ADDR_EDGECAP, 32'h0, "bit0 cleared");

    // Glitches on bit 1: 1 clock, DC-1 clocks, then exactly DC clocks.
    in_port = 4'hD;
    tick(1);
    in_port = 4'hF;
    tick(LAT + 3);
    bus_read(ADDR_EDGECAP, SHORT_GLITCH, "1-clock pulse");
    bus_write(ADDR_EDGECAP, 32'hF);
    in_port = 4'hD;
    tick(DC - 1);
    in_port = 4'hF;
    tick(LAT + 3);
    bus_read(ADDR_DATA, 32'hF, "glitch DC-1 data");
    bus_read(ADDR_EDGECAP, SHORT_GLITCH, "glitch DC-1 edgecap");
    bus_write(ADDR_EDGECAP, 32'hF);
    in_port = 4'hD;
    tick(DC);
    in_port = 4'hF;
    tick(LAT + DC + 2);
    bus_read(ADDR_EDGECAP, 32'h2, "glitch DC accepted");
    bus_read(ADDR_DATA, 32'hF, "glitch DC released");
    bus_write(ADDR_EDGECAP, 32'hF);

    // Armed bit 2: irq rises on edge LAT and falls on the clearing write edge.
    bus_write(ADDR_IRQMASK, 32'h4);
    bus_read(ADDR_IRQMASK, 32'h4, "irqmask readback");
    in_port = 4'hB;
    tick(LAT - 1);
    check("irq before latency", {31'b0, irq}, 32'h0);
    tick(1);
    check("irq on press", {31'b0, irq}, 32'h1);
    in_port = 4'hF;
    bus_write(ADDR_EDGECAP, 32'h4);
    check("irq cleared by W1C", {31'b0, irq}, 32'h0);
    bus_read(ADDR_EDGECAP, 32'h0, "bit2 cleared");
    tick(LAT + 2);

    // Press of bit 3 coincides with its clear: set wins.
    in_port = 4'h7;
    tick(LAT - 1);
    bus_write(ADDR_EDGECAP, 32'h8);
    bus_read(ADDR_EDGECAP, 32'h8, "set wins over clear");
    check("irq bit3 unarmed", {31'b0, irq}, 32'h0);
    bus_write(ADDR_IRQMASK, 32'h8);
    check("irq armed bit3", {31'b0, irq}, 32'h1);
    bus_write(ADDR_IRQMASK, 32'h0);
    check("irq masked off", {31'b0, irq}, 32'h0);
    in_port = 4'hF;
    tick(LAT + 2);

    // Reset in the middle of a bit-0 press; the held press is re-debounced after release.
    in_port = 4'hE;
    tick(3);
    reset_n = 1'b0;
    tick(1);
    check("readdata mid reset", bus.readdata, 32'h0);
    check("irq mid reset", {31'b0, irq}, 32'h0);
    reset_n = 1'b1;
    bus_read(ADDR_DATA, 32'hF, "data right after reset");
    tick(LAT - 2);
    bus_read(ADDR_EDGECAP, 32'h0, "edgecap before re-debounce");
    bus_read(ADDR_EDGECAP, 32'h1, "held press captured");
    bus_read(ADDR_DATA, 32'hE, "held press data");

    tick(3);
    check("scoreboard drained", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/problema_lcd_botao_pio.md
# problema_lcd_botao_pio

Avalon-MM slave input port for the board push-buttons; the read-side counterpart of the LED output ports on the same Nios II bus. Each bit runs through a 2-FF synchronizer and a per-bit debouncer. The block captures press (falling) edges into a sticky register and raises a maskable interrupt. Software reads the debounced level, arms interrupts per bit, and clears captured edges by bit.

## Interface
- WIDTH, 4: number of button inputs (1..32).
- DEBOUNCE_CYCLES, 500000: consecutive stable clocks required to accept a new level (10 ms at 50 MHz); minimum 1.
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- address  in  2  register select: 0 data, 1 direction, 2 irqmask, 3 edgecapture.
- chipselect  in  1  slave select.
- read_n  in  1  read strobe, active-low.
- write_n  in  1  write strobe, active-low.
- writedata  in  32  write data; only bits [WIDTH-1:0] used.
- readdata  out  32  registered read data, zero-extended.
- in_port  in  WIDTH  raw button levels, asynchronous, active-low (0 = pressed).
- irq  out  1  level interrupt, active-high.

## Operation
- Synchronizer: s1 <= in_port, s2 <= s1. Reset value is all ones.
- Debouncer (per bit):
  - A counter counts consecutive clocks with s2 != stable.
  - On the clock where the count reaches DEBOUNCE_CYCLES, stable <= s2 and the counter clears.
  - Any clock with s2 == stable clears the counter.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1). The counter saturates and never wraps.
  - stable resets to all ones (released).
- Edge detect: a bit press is the clock where stable goes 1->0. Releases are not captured.
- Register map:
  - Address 0, data: read only; reads stable. Writes are ignored.
  - Address 1, direction: reads 0; writes are ignored.
  - Address 2, irqmask: read/write. Written from writedata[WIDTH-1:0]. Reset 0.
  - Address 3, edgecapture: sticky. Reading returns the register. Writing clears each bit where writedata is 1 (write-1-to-clear). Reset 0.
- Write access is chipselect & ~write_n. Read access is chipselect & ~read_n.
- Simultaneous press and clear of the same bit in one clock: the set wins and the bit stays 1.
- irq = |(edgecapture & irqmask). It is driven from registers only, with no combinational path from the bus inputs.
- Reset mid-debounce: all counters clear and stable returns to all ones. A button held through reset is accepted after the full debounce time and is then captured as a press.

## Timing
- readdata is registered: it is valid on the clock after the read access (read latency 1). Otherwise readdata holds its last value. Reset value is 0.
- Press latency: let edge 1 be the first clk edge that samples the new in_port level. s2 updates on edge 2. stable, edgecapture and irq update on edge 2+DEBOUNCE_CYCLES.
- A glitch held for DEBOUNCE_CYCLES-1 or fewer clocks at s2 causes no change in stable.
- A write takes effect on the clock edge of the access. irq deasserts on that same edge when the last armed bit is cleared or masked.
- Reset values: readdata 0, irq 0.

## Configuration
- PROBLEMA_LCD_DEBOUNCE_EN defined: the debouncer is instantiated as described above.
- PROBLEMA_LCD_DEBOUNCE_EN undefined:
  - No counters are built, and DEBOUNCE_CYCLES is ignored.
  - stable <= s2 every clock.
  - Press latency becomes 3 edges (edge 3).
  - Register map and irq behaviour are unchanged.

## Structure
- Shared package problema_lcd_pkg holds:
  - register address constants: ADDR_DATA=0, ADDR_DIR=1, ADDR_IRQMASK=2, ADDR_EDGECAP=3;
  - the default DEBOUNCE_CYCLES constant.
- Sub-module problema_lcd_debounce is a single-bit synchronizer plus debouncer with parameter DEBOUNCE_CYCLES and output stable. Instantiate it WIDTH times in a generate loop.
- The top level holds edge detect, the registers, read mux and irq.

## Test plan
All scenarios use WIDTH=4 and DEBOUNCE_CYCLES=4 unless stated otherwise.
- Reset with in_port=4'hF, then read address 0 -> readdata=32'h0000000F one clock after the read; irq=0.
- Drive in_port[0]=0 and hold -> data reads 4'hE and edgecapture[0]=1 on edge 6. With irqmask=0, irq stays 0.
- Pulse in_port[1] low for 3 clocks -> no change in data or edgecapture.
- Write irqmask=4'h4, then press bit 2 -> irq=1 on edge 6. Write 32'h4 to address 3 -> edgecapture=0 and irq=0 on that clock.
- Press bit 3 so its capture lands on the same clock as a write of 32'h8 to address 3 -> edgecapture[3] stays 1.
- Hold in_port[0]=0, assert reset_n low mid-count, then release -> data=4'hF right after reset. The press is captured 2+4 edges after reset release.
- Build with PROBLEMA_LCD_DEBOUNCE_EN undefined and drive a 1-clock low pulse on in_port[0] -> edgecapture[0]=1.
